// File: rtl/cdc_pkg.sv
// Shared definitions for the handshake clock-crossing stages (rx now, tx later).
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } hs_state_t;

  // Width needed to count down from n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cdc_hs_rx_if.sv
// Handshake bus of the destination receive stage: request/data in, valid/ready out, ack back.
interface cdc_hs_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_req_tgl;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_ack_tgl;
  logic                  o_ovf;
  logic                  i_ovf_clr;

  modport slave (
    input  i_req_tgl, i_data, i_ready, i_ovf_clr,
    output o_data, o_valid, o_ack_tgl, o_ovf
  );

  modport master (
    output i_req_tgl, i_data, i_ready, i_ovf_clr,
    input  o_data, o_valid, o_ack_tgl, o_ovf
  );
endinterface

// File: rtl/cdc_hs_rx_toggle_edge_det.sv
// Remembers the last serviced request toggle level; the owner decides when to update it.
module toggle_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  input  logic upd,
  output logic last,
  output logic mismatch
);

  logic last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= 1'b0;
    end else if (upd) begin
      last_reg <= tgl;
    end
  end

  assign last     = last_reg;
  assign mismatch = (tgl != last_reg);

endmodule

// File: rtl/cdc_hs_rx.sv
// Destination receive stage: detect request toggle, wait for the bus to settle,
// capture it, present it with valid/ready and return an ack toggle.
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    SETTLE_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input logic       i_clk,
  input logic       i_rst,
  cdc_hs_rx_if.slave bus
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

  hs_state_t             state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic                  ack_reg, ack_next;
  logic                  ovf_reg, ovf_next;
  logic                  upd;
  logic                  req_last;
  logic                  mismatch;

  toggle_edge_det u_det (
    .clk      (i_clk),
    .rst      (i_rst),
    .tgl      (bus.i_req_tgl),
    .upd      (upd),
    .last     (req_last),
    .mismatch (mismatch)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      data_reg  <= RESET_VALUE;
      valid_reg <= 1'b0;
      ack_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ack_reg   <= ack_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    ack_next   = ack_reg;
    upd        = 1'b0;
    // A re-toggle while a word is in flight sets the flag; set beats clear.
    ovf_next   = (ovf_reg & ~bus.i_ovf_clr) | (mismatch && (state_reg != IDLE));

    case (state_reg)
      IDLE: begin
        if (mismatch) begin
          upd = 1'b1;
          if (SETTLE_CYCLES > 0) begin
            cnt_next   = CNT_LOAD;
            state_next = SETTLE;
          end else begin
            data_next  = bus.i_data;
            valid_next = 1'b1;
            state_next = HOLD;
          end
        end
      end
      SETTLE: begin
        if (cnt_reg == '0) begin
          data_next  = bus.i_data;
          valid_next = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      HOLD: begin
        if (valid_reg && bus.i_ready) begin
          valid_next = 1'b0;
          ack_next   = ~ack_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.o_data    = data_reg;
  assign bus.o_valid   = valid_reg;
  assign bus.o_ack_tgl = ack_reg;
  assign bus.o_ovf     = ovf_reg;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Bench for cdc_hs_rx: a SETTLE_CYCLES=2 instance and a SETTLE_CYCLES=0 instance, scoreboard on accepted words.
module tb_cdc_hs_rx;

  logic clk = 1'b0;
  logic rst;
  logic rst0;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] q2[$];
  logic [7:0] q0[$];

  always #5 clk = ~clk;

  cdc_hs_rx_if #(.DATA_WIDTH(8)) a ();
  cdc_hs_rx_if #(.DATA_WIDTH(8)) b ();

  cdc_hs_rx #(.DATA_WIDTH(8), .SETTLE_CYCLES(2), .RESET_VALUE(8'h00)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (a.slave)
  );

  cdc_hs_rx #(.DATA_WIDTH(8), .SETTLE_CYCLES(0), .RESET_VALUE(8'h00)) u_dut0 (
    .i_clk (clk),
    .i_rst (rst0),
    .bus   (b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until o_valid is seen, bounded.
  task automatic wait_valid(input bit use0, output int n);
    n = 0;
    while (((use0 ? b.o_valid : a.o_valid) !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("valid_timeout", 32'd1, 32'd0);
  endtask

  // Scoreboard: an acceptance happens on the next edge whenever valid & ready are both high now.
  always @(negedge clk) begin
    if (!rst && a.o_valid === 1'b1 && a.i_ready === 1'b1) begin
      if (q2.size() == 0) chk("a_unexpected", 32'd1, 32'd0);
      else begin
        logic [7:0] e;
        e = q2.pop_front();
        $display("xfer a data=%02h exp=%02h", a.o_data, e);
        chk("a_data", a.o_data, e);
      end
    end
    if (!rst0 && b.o_valid === 1'b1 && b.i_ready === 1'b1) begin
      if (q0.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
      else begin
        logic [7:0] e;
        e = q0.pop_front();
        $display("xfer b data=%02h exp=%02h", b.o_data, e);
        chk("b_data", b.o_data, e);
      end
    end
  end

  initial begin
    int n;
    logic ack_exp;
    rst = 1'b1; rst0 = 1'b1;
    a.i_req_tgl = 1'b1; a.i_data = 8'h5A; a.i_ready = 1'b1; a.i_ovf_clr = 1'b0;
    b.i_req_tgl = 1'b0; b.i_data = 8'h00; b.i_ready = 1'b0; b.i_ovf_clr = 1'b0;

    // Reset with a pending toggle level of 1
    repeat (3) tick();
    chk("rst_valid", a.o_valid, 0);
    chk("rst_data", a.o_data, 8'h00);
    chk("rst_ack", a.o_ack_tgl, 0);
    chk("rst_ovf", a.o_ovf, 0);
    rst = 1'b0; rst0 = 1'b0;
    q2.push_back(8'h5A);
    wait_valid(1'b0, n);
    chk("rst_lat", n, 3);
    tick();
    ack_exp = 1'b1;
    chk("rst_xfer_valid", a.o_valid, 0);
    chk("rst_xfer_ack", a.o_ack_tgl, ack_exp);

    // Basic transfer, one-cycle valid pulse
    a.i_data = 8'hA5; a.i_req_tgl = ~a.i_req_tgl; q2.push_back(8'hA5);
    wait_valid(1'b0, n);
    chk("basic_lat", n, 3);
    chk("basic_data", a.o_data, 8'hA5);
    tick();
    ack_exp = ~ack_exp;
    chk("basic_pulse", a.o_valid, 0);
    chk("basic_ack", a.o_ack_tgl, ack_exp);

    // Backpressure: data frozen while ready is low
    a.i_ready = 1'b0;
    a.i_req_tgl = ~a.i_req_tgl; q2.push_back(8'hA5);
    wait_valid(1'b0, n);
    chk("bp_lat", n, 3);
    a.i_data = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", a.o_valid, 1);
      chk("bp_data", a.o_data, 8'hA5);
      chk("bp_ack", a.o_ack_tgl, ack_exp);
    end
    a.i_ready = 1'b1;
    tick();
    ack_exp = ~ack_exp;
    chk("bp_accept_valid", a.o_valid, 0);
    chk("bp_accept_ack", a.o_ack_tgl, ack_exp);
    tick();
    chk("bp_ack_once", a.o_ack_tgl, ack_exp);

    // Back-to-back words
    for (int k = 1; k <= 4; k++) begin
      a.i_data = 8'(k); a.i_req_tgl = ~a.i_req_tgl; q2.push_back(8'(k));
      wait_valid(1'b0, n);
      chk("b2b_lat", n, 3);
      tick();
      ack_exp = ~ack_exp;
      chk("b2b_ack", a.o_ack_tgl, ack_exp);
    end
    chk("b2b_ovf", a.o_ovf, 0);

    // Overflow: re-toggle during HOLD
    a.i_ready = 1'b0;
    a.i_data = 8'h77; a.i_req_tgl = ~a.i_req_tgl; q2.push_back(8'h77);
    wait_valid(1'b0, n);
    a.i_data = 8'h88; a.i_req_tgl = ~a.i_req_tgl; q2.push_back(8'h88);
    tick();
    chk("ovf_set", a.o_ovf, 1);
    chk("ovf_hold_data", a.o_data, 8'h77);
    a.i_ready = 1'b1;
    tick();
    ack_exp = ~ack_exp;
    wait_valid(1'b0, n);
    chk("ovf_second_lat", n, 3);
    chk("ovf_second_data", a.o_data, 8'h88);
    tick();
    ack_exp = ~ack_exp;
    chk("ovf_second_ack", a.o_ack_tgl, ack_exp);
    chk("ovf_sticky", a.o_ovf, 1);
    a.i_ovf_clr = 1'b1; tick(); a.i_ovf_clr = 1'b0;
    chk("ovf_clear", a.o_ovf, 0);

    // Clear coinciding with a new violation keeps the flag set
    a.i_ready = 1'b0;
    a.i_data = 8'h99; a.i_req_tgl = ~a.i_req_tgl; q2.push_back(8'h99);
    wait_valid(1'b0, n);
    a.i_data = 8'hAA; a.i_req_tgl = ~a.i_req_tgl; q2.push_back(8'hAA);
    a.i_ovf_clr = 1'b1;
    tick();
    a.i_ovf_clr = 1'b0;
    chk("ovf_set_beats_clr", a.o_ovf, 1);
    a.i_ready = 1'b1;
    tick();
    ack_exp = ~ack_exp;
    wait_valid(1'b0, n);
    tick();
    ack_exp = ~ack_exp;
    chk("ovf2_ack", a.o_ack_tgl, ack_exp);
    a.i_ovf_clr = 1'b1; tick(); a.i_ovf_clr = 1'b0;
    chk("ovf_clear2", a.o_ovf, 0);

    // Zero-settle build: reset during HOLD, then a normal transfer
    b.i_data = 8'hD4; b.i_req_tgl = 1'b1;
    wait_valid(1'b1, n);
    chk("s0_lat", n, 1);
    chk("s0_data", b.o_data, 8'hD4);
    rst0 = 1'b1;
    b.i_data = 8'hC3;
    tick();
    chk("s0_rst_valid", b.o_valid, 0);
    chk("s0_rst_ack", b.o_ack_tgl, 0);
    chk("s0_rst_data", b.o_data, 8'h00);
    rst0 = 1'b0; b.i_ready = 1'b1; q0.push_back(8'hC3);
    wait_valid(1'b1, n);
    chk("s0_lat2", n, 1);
    tick();
    chk("s0_pulse", b.o_valid, 0);
    chk("s0_ack", b.o_ack_tgl, 1);

    tick();
    chk("a_queue_empty", q2.size(), 0);
    chk("b_queue_empty", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_hs_rx.md
Name: cdc_hs_rx

Overview:
- Destination-domain receive stage of the team's multi-bit clock-crossing scheme.
- Sits directly downstream of CLKCROSSDFF: consumes the synchronized request toggle it produces, plus a quasi-static data bus held by the source.
- Waits a settle interval, captures the bus, and presents it with valid/ready.
- Returns an ack toggle that goes back to the source through a second CLKCROSSDFF.

Parameters:
- DATA_WIDTH, 8, width of the crossed data bus.
- SETTLE_CYCLES, 2, destination clocks to wait after toggle detection before capturing i_data (0 allowed).
- RESET_VALUE, {DATA_WIDTH{1'b0}}, reset value of o_data.

Ports:
- i_clk  input  1  destination clock.
- i_rst  input  1  synchronous, active-high reset.
- i_req_tgl  input  1  request toggle, already synchronized into i_clk (CLKCROSSDFF output).
- i_data  input  DATA_WIDTH  source data bus; source holds it stable from its req toggle until it sees ack.
- o_data  output  DATA_WIDTH  captured data.
- o_valid  output  1  o_data holds an unconsumed word.
- i_ready  input  1  downstream accepts the word when o_valid & i_ready.
- o_ack_tgl  output  1  acknowledge toggle to the source domain.
- o_ovf  output  1  sticky protocol-violation flag.
- i_ovf_clr  input  1  clears o_ovf.

Behaviour:
- Everything is sampled on the rising edge of i_clk. Reset is synchronous and active-high.
- On reset: state IDLE, o_valid=0, o_data=RESET_VALUE, o_ack_tgl=0, o_ovf=0, req_last=0, settle counter=0. Reset mid-transfer abandons the word and sends no ack.
- State machine (IDLE, SETTLE, HOLD):
  - IDLE: a new request is i_req_tgl != req_last.
    - On a new request, req_last <= i_req_tgl.
    - If SETTLE_CYCLES>0: load counter with SETTLE_CYCLES-1 and go to SETTLE.
    - Else: capture directly (o_data <= i_data, o_valid <= 1) and go to HOLD.
  - SETTLE: decrement the counter each cycle. At 0: o_data <= i_data, o_valid <= 1, go to HOLD.
  - HOLD: o_valid=1 and o_data is frozen. On o_valid & i_ready:
    - o_valid <= 0 and o_ack_tgl <= ~o_ack_tgl on the same edge.
    - Go to IDLE.
- Latency: with the detect edge as cycle 0, o_valid is high from cycle SETTLE_CYCLES+1.
- Ready rules: i_ready high on the first valid cycle gives a one-cycle o_valid pulse. i_ready has no effect outside HOLD.
- Throughput: the earliest next detection is the cycle after the accepting edge, i.e. one word per SETTLE_CYCLES+2 clocks minimum. The crossing round-trip dominates in practice.
- Overflow: in SETTLE or HOLD, i_req_tgl != req_last means the source re-toggled before ack.
  - Set o_ovf. It is sticky until i_ovf_clr; a simultaneous set and clear leaves it set.
  - The in-flight word is unaffected.
  - The mismatch remains pending and is serviced as a new request on return to IDLE, which recaptures whatever is currently on i_data.
- Counter width: $clog2(SETTLE_CYCLES+1), minimum 1 bit.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Shared package cdc_pkg:
  - State localparams IDLE/SETTLE/HOLD.
  - A clog2-based counter-width function, reused by a future cdc_hs_tx.
- One natural sub-module: toggle_edge_det.
  - Holds req_last and flags a mismatch.
  - Has an update-enable so the FSM controls when req_last is loaded.

Test Plan:
1. Reset: hold i_rst 3 cycles with i_req_tgl=1 -> o_valid=0, o_data=0, o_ack_tgl=0, o_ovf=0. After release, the request is detected the next cycle.
2. Basic transfer, SETTLE_CYCLES=2, i_ready=1: i_data=8'hA5, flip i_req_tgl at cycle 0 -> o_valid high exactly 1 cycle at cycle 3 with o_data=8'hA5. o_ack_tgl flips at the end of cycle 3.
3. Backpressure: i_ready=0 for 5 cycles while i_data changes to 8'h3C -> o_data stays 8'hA5 and o_valid stays 1. On i_ready=1, acceptance happens on one edge and ack flips once.
4. Back-to-back: four toggles, each issued one cycle after the previous ack, data 01/02/03/04 -> four accepted words in order, ack toggles 4 times, o_ovf=0.
5. Overflow: re-toggle i_req_tgl during HOLD -> o_ovf=1 next cycle. After acceptance a second word is captured. Asserting i_ovf_clr together with a new violation keeps o_ovf=1; asserting it alone clears it.
6. SETTLE_CYCLES=0 build: toggle at cycle 0 -> o_valid at cycle 1. Reset asserted during HOLD -> o_valid=0 next cycle and no ack flip.
